// File: rtl/issue_dispatch_ctrl_pkg.sv
// Shared types for the issue dispatch controller: head-slot payload, FSM states
// and block-cause encoding.
package issue_dispatch_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [2:0] {
        BLK_NONE   = 3'd0,
        BLK_EMPTY  = 3'd1,
        BLK_RAW    = 3'd2,
        BLK_LDUSE  = 3'd3,
        BLK_STRUCT = 3'd4,
        BLK_DIV    = 3'd5,
        BLK_SERIAL = 3'd6,
        BLK_STALL  = 3'd7
    } blk_cause_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SER   = 2'd2,
        ST_POST  = 2'd3
    } dispatch_state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             rf_we;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             is_load;
        logic             is_mem;
        logic             is_div;
        logic             is_ser;
    } slot_t;

    // True when slot s sources architectural register r (r0 never creates a dependency).
    function automatic logic reads_reg(input slot_t s, input logic [REG_W-1:0] r);
        return (r != '0) && ((s.rs1 == r) || (s.rs2 == r));
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Combinational check deciding whether head slot 1 may pair with slot 0,
// reporting the highest-priority reason when it may not.
module issue_pair_check
    import issue_dispatch_ctrl_pkg::*;
(
    input  slot_t      h0,
    input  slot_t      h1,
    input  logic       div_busy,
    input  logic       h1_ld_use,
    output logic       ok,
    output blk_cause_t cause
);

    logic raw;
    logic waw;
    logic mem_pair;
    logic div_hit;
    logic unused_fields;

    assign unused_fields = ^{h0.valid, h0.rs1, h0.rs2, h0.is_ser, h1.is_load};

    always_comb begin
        raw      = h0.rf_we && reads_reg(h1, h0.rd);
        waw      = h0.rf_we && h1.rf_we && (h0.rd == h1.rd) && (h0.rd != '0);
        mem_pair = h0.is_mem && h1.is_mem;
        div_hit  = h1.is_div && (h0.is_div || div_busy);

        cause = BLK_NONE;
        if (h1.valid && h1.is_ser)             cause = BLK_SERIAL;
        else if (!h1.valid)                    cause = BLK_EMPTY;
        else if (h1_ld_use)                    cause = BLK_LDUSE;
        else if (div_hit)                      cause = BLK_DIV;
        else if (raw)                          cause = BLK_RAW;
        else if (waw || mem_pair || h0.is_load) cause = BLK_STRUCT;

        ok = (cause == BLK_NONE);
    end

endmodule

// File: rtl/issue_dispatch_ctrl.sv
// Per-cycle dual-issue decision between the issue buffer heads and the EX register,
// with load-use scoreboard, divider occupancy and CSR serialisation.
module issue_dispatch_ctrl
    import issue_dispatch_ctrl_pkg::*;
#(
    parameter int unsigned DIV_LAT = 18,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             h0_valid,
    input  logic             h1_valid,
    input  logic [4:0]       h0_rd,
    input  logic [4:0]       h1_rd,
    input  logic             h0_rf_we,
    input  logic             h1_rf_we,
    input  logic [4:0]       h0_rs1,
    input  logic [4:0]       h0_rs2,
    input  logic [4:0]       h1_rs1,
    input  logic [4:0]       h1_rs2,
    input  logic             h0_is_load,
    input  logic             h1_is_load,
    input  logic             h0_is_mem,
    input  logic             h1_is_mem,
    input  logic             h0_is_div,
    input  logic             h1_is_div,
    input  logic             h0_is_ser,
    input  logic             h1_is_ser,
    input  logic             pipe_empty,
    input  logic             flush_BR,
    input  logic             stall_DCache,
    input  logic             stall_div,
    output logic             issue_v0,
    output logic             issue_v1,
    output logic [1:0]       pop_num,
    output logic [2:0]       blk_cause,
    output logic [CNT_W-1:0] dual_cnt,
    output logic [CNT_W-1:0] single_cnt
);

    localparam int unsigned DIV_W = $clog2(DIV_LAT + 1);

    slot_t           s0;
    slot_t           s1;
    dispatch_state_t state;
    dispatch_state_t state_nxt;
    logic            ld_pend_v;
    logic [REG_W-1:0] ld_pend_rd;
    logic [DIV_W-1:0] div_cnt;
    logic            stall;
    logic            div_busy;
    logic            lu0;
    logic            lu1;
    logic            ser_head;
    logic            pair_ok;
    logic            div_issue;
    blk_cause_t      pair_cause;
    blk_cause_t      cause_nxt;

    assign s0 = '{valid: h0_valid, rd: h0_rd, rf_we: h0_rf_we, rs1: h0_rs1, rs2: h0_rs2,
                  is_load: h0_is_load, is_mem: h0_is_mem, is_div: h0_is_div, is_ser: h0_is_ser};
    assign s1 = '{valid: h1_valid, rd: h1_rd, rf_we: h1_rf_we, rs1: h1_rs1, rs2: h1_rs2,
                  is_load: h1_is_load, is_mem: h1_is_mem, is_div: h1_is_div, is_ser: h1_is_ser};

    issue_pair_check u_pair (
        .h0        (s0),
        .h1        (s1),
        .div_busy  (div_busy),
        .h1_ld_use (lu1),
        .ok        (pair_ok),
        .cause     (pair_cause)
    );

    // Issue decision, next state and block cause for this cycle.
    always_comb begin
        stall     = stall_DCache | stall_div;
        div_busy  = (div_cnt != '0);
        lu0       = ld_pend_v && reads_reg(s0, ld_pend_rd);
        lu1       = ld_pend_v && reads_reg(s1, ld_pend_rd);
        ser_head  = s0.valid && s0.is_ser;
        issue_v0  = 1'b0;
        issue_v1  = 1'b0;
        cause_nxt = BLK_NONE;
        state_nxt = state;

        if (flush_BR || stall) begin
            cause_nxt = BLK_STALL;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ser_head) begin
                        cause_nxt = BLK_SERIAL;
                        state_nxt = ST_DRAIN;
                    end else if (!s0.valid)          cause_nxt = BLK_EMPTY;
                    else if (lu0)                    cause_nxt = BLK_LDUSE;
                    else if (s0.is_div && div_busy)  cause_nxt = BLK_DIV;
                    else begin
                        issue_v0  = rstn;
                        issue_v1  = rstn && pair_ok;
                        cause_nxt = pair_cause;
                    end
                end
                ST_DRAIN: begin
                    cause_nxt = BLK_SERIAL;
                    if (pipe_empty) state_nxt = ST_SER;
                end
                ST_SER: begin
                    if (s0.valid) begin
                        issue_v0  = rstn;
                        cause_nxt = BLK_SERIAL;
                        state_nxt = ST_POST;
                    end else begin
                        cause_nxt = BLK_EMPTY;
                    end
                end
                default: begin
                    cause_nxt = BLK_SERIAL;
                    if (pipe_empty) state_nxt = ST_RUN;
                end
            endcase
        end

        pop_num   = {1'b0, issue_v0} + {1'b0, issue_v1};
        div_issue = (issue_v0 && s0.is_div) || (issue_v1 && s1.is_div);
    end

    // Flush clears speculative tracking; stall freezes everything but the divider countdown.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_RUN;
            ld_pend_v  <= 1'b0;
            ld_pend_rd <= '0;
            div_cnt    <= '0;
            blk_cause  <= '0;
            dual_cnt   <= '0;
            single_cnt <= '0;
        end else begin
            blk_cause <= cause_nxt;
            if (flush_BR) begin
                state     <= ST_RUN;
                ld_pend_v <= 1'b0;
                div_cnt   <= '0;
            end else begin
                if (div_issue)     div_cnt <= DIV_W'(DIV_LAT);
                else if (div_busy) div_cnt <= div_cnt - DIV_W'(1);

                if (!stall) begin
                    state <= state_nxt;
                    if (issue_v1 && s1.is_load && s1.rf_we && (s1.rd != '0)) begin
                        ld_pend_v  <= 1'b1;
                        ld_pend_rd <= s1.rd;
                    end else if (issue_v0 && s0.is_load && s0.rf_we && (s0.rd != '0)) begin
                        ld_pend_v  <= 1'b1;
                        ld_pend_rd <= s0.rd;
                    end else begin
                        ld_pend_v  <= 1'b0;
                    end

                    if (issue_v0 && issue_v1) dual_cnt   <= dual_cnt + CNT_W'(1);
                    else if (issue_v0)        single_cnt <= single_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Directed scoreboard bench for issue_dispatch_ctrl: stimulus pushes the expected
// per-cycle response, a negedge monitor pops and compares.
module tb_issue_dispatch_ctrl;

    logic        clk;
    logic        rstn;
    logic        h0_valid, h1_valid;
    logic [4:0]  h0_rd, h1_rd;
    logic        h0_rf_we, h1_rf_we;
    logic [4:0]  h0_rs1, h0_rs2, h1_rs1, h1_rs2;
    logic        h0_is_load, h1_is_load;
    logic        h0_is_mem, h1_is_mem;
    logic        h0_is_div, h1_is_div;
    logic        h0_is_ser, h1_is_ser;
    logic        pipe_empty;
    logic        flush_BR;
    logic        stall_DCache, stall_div;
    logic        issue_v0, issue_v1;
    logic [1:0]  pop_num;
    logic [2:0]  blk_cause;
    logic [31:0] dual_cnt, single_cnt;

    typedef struct packed {
        logic        v0;
        logic        v1;
        logic [1:0]  pop;
        logic        chk_cause;
        logic [2:0]  cause;
        logic [31:0] dual;
        logic [31:0] single;
        logic [15:0] tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_r;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_dual = 0;
    int   exp_single = 0;

    issue_dispatch_ctrl #(.DIV_LAT(18), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .h0_valid(h0_valid), .h1_valid(h1_valid),
        .h0_rd(h0_rd), .h1_rd(h1_rd),
        .h0_rf_we(h0_rf_we), .h1_rf_we(h1_rf_we),
        .h0_rs1(h0_rs1), .h0_rs2(h0_rs2), .h1_rs1(h1_rs1), .h1_rs2(h1_rs2),
        .h0_is_load(h0_is_load), .h1_is_load(h1_is_load),
        .h0_is_mem(h0_is_mem), .h1_is_mem(h1_is_mem),
        .h0_is_div(h0_is_div), .h1_is_div(h1_is_div),
        .h0_is_ser(h0_is_ser), .h1_is_ser(h1_is_ser),
        .pipe_empty(pipe_empty), .flush_BR(flush_BR),
        .stall_DCache(stall_DCache), .stall_div(stall_div),
        .issue_v0(issue_v0), .issue_v1(issue_v1), .pop_num(pop_num),
        .blk_cause(blk_cause), .dual_cnt(dual_cnt), .single_cnt(single_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest expected record each mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_r = q.pop_front();
            check("issue_v0",   int'(mon_r.tag), 32'(issue_v0),  32'(mon_r.v0));
            check("issue_v1",   int'(mon_r.tag), 32'(issue_v1),  32'(mon_r.v1));
            check("pop_num",    int'(mon_r.tag), 32'(pop_num),   32'(mon_r.pop));
            check("dual_cnt",   int'(mon_r.tag), dual_cnt,       mon_r.dual);
            check("single_cnt", int'(mon_r.tag), single_cnt,     mon_r.single);
            if (mon_r.chk_cause)
                check("blk_cause", int'(mon_r.tag), 32'(blk_cause), 32'(mon_r.cause));
        end
    end

    task automatic set_h0(input logic v, input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic ld, input logic mem, input logic dv,
                          input logic ser);
        h0_valid = v; h0_rd = rd; h0_rf_we = we; h0_rs1 = rs1; h0_rs2 = rs2;
        h0_is_load = ld; h0_is_mem = mem; h0_is_div = dv; h0_is_ser = ser;
    endtask

    task automatic set_h1(input logic v, input logic [4:0] rd, input logic we, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic ld, input logic mem, input logic dv,
                          input logic ser);
        h1_valid = v; h1_rd = rd; h1_rf_we = we; h1_rs1 = rs1; h1_rs2 = rs2;
        h1_is_load = ld; h1_is_mem = mem; h1_is_div = dv; h1_is_ser = ser;
    endtask

    task automatic clr();
        set_h0(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_h1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush_BR = 0; stall_DCache = 0; stall_div = 0; pipe_empty = 0;
    endtask

    // Push this cycle's expectation (cause = value visible now, i.e. from the previous cycle).
    task automatic step(input logic ev0, input logic ev1, input logic cc, input logic [2:0] ec);
        exp_t e;
        e.v0 = ev0; e.v1 = ev1; e.pop = {1'b0, ev0} + {1'b0, ev1};
        e.chk_cause = cc; e.cause = ec;
        e.dual = 32'(exp_dual); e.single = 32'(exp_single); e.tag = 16'(cyc);
        q.push_back(e);
        @(posedge clk);
        #1;
        if (ev0 && ev1)      exp_dual++;
        else if (ev0 || ev1) exp_single++;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        clr();
        @(posedge clk);
        #1;
        // Reset: outputs gated even with a valid head.
        set_h0(1, 5, 1, 1, 2, 0, 0, 0, 0);
        step(0, 0, 1, 3'd0);
        rstn = 1'b1;
        clr();
        step(0, 0, 1, 3'd0);
        // Independent pair.
        set_h0(1, 5, 1, 1, 2, 0, 0, 0, 0); set_h1(1, 8, 1, 6, 7, 0, 0, 0, 0);
        step(1, 1, 1, 3'd1);
        // RAW inside the pair.
        set_h1(1, 9, 1, 5, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3'd0);
        clr();
        step(0, 0, 1, 3'd2);
        // Load to r7 (no pairing after a load), then load-use bubble.
        set_h0(1, 7, 1, 1, 0, 1, 1, 0, 0); set_h1(1, 10, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3'd1);
        clr(); set_h0(1, 11, 1, 1, 7, 0, 0, 0, 0);
        step(0, 0, 1, 3'd4);
        step(1, 0, 1, 3'd3);
        // Two memory ops, then WAW.
        set_h0(1, 0, 0, 2, 3, 0, 1, 0, 0); set_h1(1, 12, 1, 4, 0, 1, 1, 0, 0);
        step(1, 0, 1, 3'd1);
        set_h0(1, 13, 1, 1, 0, 0, 0, 0, 0); set_h1(1, 13, 1, 2, 0, 0, 0, 0, 0);
        step(1, 0, 1, 3'd4);
        // Stall blocks an otherwise dual-issuable pair; slot 1 load then issues.
        set_h0(1, 14, 1, 1, 2, 0, 0, 0, 0); set_h1(1, 15, 1, 3, 0, 1, 1, 0, 0);
        stall_DCache = 1;
        step(0, 0, 1, 3'd4);
        stall_DCache = 0;
        step(1, 1, 1, 3'd7);
        // Flush clears the pending load so the consumer issues right after.
        clr(); set_h0(1, 16, 1, 15, 0, 0, 0, 0, 0); flush_BR = 1;
        step(0, 0, 1, 3'd0);
        flush_BR = 0;
        step(1, 0, 0, 3'd0);
        // Div pair, then a second div waits out the divider with a stall in the window.
        set_h0(1, 17, 1, 1, 2, 0, 0, 1, 0); set_h1(1, 18, 1, 3, 4, 0, 0, 1, 0);
        step(1, 0, 1, 3'd1);
        clr(); set_h0(1, 18, 1, 3, 4, 0, 0, 1, 0);
        for (int k = 1; k <= 18; k++) begin
            stall_div = (k >= 5 && k <= 7);
            step(0, 0, 1, (k >= 6 && k <= 8) ? 3'd7 : 3'd5);
        end
        stall_div = 0;
        step(1, 0, 1, 3'd5);
        // CSR serialisation: RUN -> DRAIN x3 -> SER -> POST -> RUN.
        set_h0(1, 4, 1, 1, 0, 0, 0, 0, 1); set_h1(1, 20, 1, 2, 3, 0, 0, 0, 0);
        step(0, 0, 1, 3'd1);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 3'd6);
        pipe_empty = 1;
        step(0, 0, 1, 3'd6);
        step(1, 0, 1, 3'd6);
        set_h0(1, 20, 1, 2, 3, 0, 0, 0, 0); set_h1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pipe_empty = 0;
        step(0, 0, 1, 3'd6);
        pipe_empty = 1;
        step(0, 0, 1, 3'd6);
        step(1, 0, 1, 3'd6);
        // Flush mid-DRAIN aborts serialisation; the refetched CSR starts over from RUN.
        set_h0(1, 4, 1, 1, 0, 0, 0, 0, 1); pipe_empty = 0;
        step(0, 0, 1, 3'd1);
        flush_BR = 1;
        step(0, 0, 1, 3'd6);
        flush_BR = 0; pipe_empty = 1;
        step(0, 0, 0, 3'd0);
        step(0, 0, 1, 3'd6);
        step(1, 0, 1, 3'd6);
        // Reset asserted mid-POST: outputs and counters drop at once, FSM back to RUN.
        set_h0(1, 21, 1, 1, 0, 0, 0, 0, 0); pipe_empty = 0;
        step(0, 0, 1, 3'd6);
        rstn = 1'b0;
        exp_dual = 0; exp_single = 0;
        step(0, 0, 1, 3'd0);
        rstn = 1'b1;
        set_h1(1, 22, 1, 2, 3, 0, 0, 0, 0);
        step(1, 1, 1, 3'd0);
        clr();
        step(0, 0, 1, 3'd0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", cyc, 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
